// File: rtl/victim_cache_ctrl.sv
// Victim cache controller: slot bookkeeping, L1 miss lookups, round-robin allocation
// and dirty-victim writeback. Optional hit/miss counters are enabled with VICTIM_CTRL_STAT_EN.
module victim_cache_ctrl #(
  parameter int SIZE          = 4,
  parameter int INDEX_WIDTH   = 6,
  parameter int TAG_WIDTH     = 20,
  parameter int LINE_WORD_NUM = 16,
  localparam int SLOT_W       = $clog2(SIZE),
  localparam int LINE_W       = LINE_WORD_NUM * 32
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic                              miss_req,
  input  logic [TAG_WIDTH-1:0]              miss_tag,
  input  logic [INDEX_WIDTH-1:0]            miss_index,
  output logic                              miss_ack,
  output logic                              resp_valid,
  output logic                              resp_hit,
  output logic                              resp_dirty,
  output logic [LINE_W-1:0]                 resp_line,
`ifdef VICTIM_CTRL_STAT_EN
  output logic [31:0]                       stat_hit,
  output logic [31:0]                       stat_miss,
`endif
  input  logic                              evict_valid,
  input  logic [TAG_WIDTH-1:0]              evict_tag,
  input  logic [INDEX_WIDTH-1:0]            evict_index,
  input  logic                              evict_dirty,
  output logic                              evict_done,
  output logic [SLOT_W-1:0]                 vc_slot,
  output logic                              vc_we,
  output logic                              vc_read_en,
  output logic [TAG_WIDTH+INDEX_WIDTH:0]    vc_tagvindex_wdata,
  input  logic [LINE_W-1:0]                 vc_data_rdata,
  output logic                              wb_valid,
  input  logic                              wb_ready,
  output logic [TAG_WIDTH+INDEX_WIDTH-1:0]  wb_addr,
  output logic [LINE_W-1:0]                 wb_data
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOOKUP   = 3'd1;
  localparam logic [2:0] S_HIT_DATA = 3'd2;
  localparam logic [2:0] S_WB_RD    = 3'd3;
  localparam logic [2:0] S_WB_LATCH = 3'd4;
  localparam logic [2:0] S_WB_SEND  = 3'd5;
  localparam logic [2:0] S_ALLOC    = 3'd6;

  logic [2:0]                         state_q, state_d;
  logic [SIZE-1:0]                    valid_q, valid_d;
  logic [SIZE-1:0]                    dirty_q, dirty_d;
  logic [TAG_WIDTH-1:0]               tag_q   [SIZE];
  logic [TAG_WIDTH-1:0]               tag_d   [SIZE];
  logic [INDEX_WIDTH-1:0]             index_q [SIZE];
  logic [INDEX_WIDTH-1:0]             index_d [SIZE];
  logic [SLOT_W-1:0]                  rr_ptr_q, rr_ptr_d;
  logic [SLOT_W-1:0]                  slot_q, slot_d;
  logic                               hit_q, hit_d;
  logic [TAG_WIDTH+INDEX_WIDTH-1:0]   wb_addr_q, wb_addr_d;
  logic [LINE_W-1:0]                  wb_data_q, wb_data_d;

  logic                               miss_hit;
  logic [SLOT_W-1:0]                  miss_slot;
  logic                               ev_match;
  logic [SLOT_W-1:0]                  ev_match_slot;
  logic                               inv_found;
  logic [SLOT_W-1:0]                  inv_slot;
  logic [SLOT_W-1:0]                  ev_target;
  logic                               ev_use_rr;

  // Associative search of all slots for the lookup, the victim, and the first free slot.
  always_comb begin
    miss_hit      = 1'b0;
    miss_slot     = '0;
    ev_match      = 1'b0;
    ev_match_slot = '0;
    inv_found     = 1'b0;
    inv_slot      = '0;
    for (int i = 0; i < SIZE; i++) begin
      if (valid_q[i] && tag_q[i] == miss_tag && index_q[i] == miss_index) begin
        miss_hit  = 1'b1;
        miss_slot = SLOT_W'(i);
      end
      if (valid_q[i] && tag_q[i] == evict_tag && index_q[i] == evict_index) begin
        ev_match      = 1'b1;
        ev_match_slot = SLOT_W'(i);
      end
      if (!valid_q[i] && !inv_found) begin
        inv_found = 1'b1;
        inv_slot  = SLOT_W'(i);
      end
    end
  end

  always_comb begin
    ev_use_rr = 1'b0;
    if (ev_match) begin
      ev_target = ev_match_slot;
    end else if (inv_found) begin
      ev_target = inv_slot;
    end else begin
      ev_target = rr_ptr_q;
      ev_use_rr = 1'b1;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default here so no path leaves one unassigned, which would infer a latch.
    state_d            = state_q;
    valid_d            = valid_q;
    dirty_d            = dirty_q;
    tag_d              = tag_q;
    index_d            = index_q;
    rr_ptr_d           = rr_ptr_q;
    slot_d             = slot_q;
    hit_d              = hit_q;
    wb_addr_d          = wb_addr_q;
    wb_data_d          = wb_data_q;
    miss_ack           = 1'b0;
    resp_valid         = 1'b0;
    resp_hit           = 1'b0;
    resp_dirty         = 1'b0;
    resp_line          = '0;
    evict_done         = 1'b0;
    vc_slot            = '0;
    vc_we              = 1'b0;
    vc_read_en         = 1'b0;
    vc_tagvindex_wdata = '0;
    wb_valid           = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (miss_req) begin
          miss_ack = 1'b1;
          hit_d    = miss_hit;
          slot_d   = miss_slot;
          state_d  = S_LOOKUP;
        end else if (evict_valid) begin
          slot_d = ev_target;
          if (ev_use_rr) begin
            rr_ptr_d = rr_ptr_q + 1'b1;
          end
          if (valid_q[ev_target] && dirty_q[ev_target] && !ev_match) begin
            state_d = S_WB_RD;
          end else begin
            state_d = S_ALLOC;
          end
        end
      end
      S_LOOKUP: begin
        if (hit_q) begin
          vc_slot    = slot_q;
          vc_read_en = 1'b1;
          state_d    = S_HIT_DATA;
        end else begin
          resp_valid = 1'b1;
          state_d    = S_IDLE;
        end
      end
      S_HIT_DATA: begin
        // The line returns to L1, so the slot is released.
        resp_valid      = 1'b1;
        resp_hit        = 1'b1;
        resp_dirty      = dirty_q[slot_q];
        resp_line       = vc_data_rdata;
        valid_d[slot_q] = 1'b0;
        dirty_d[slot_q] = 1'b0;
        state_d         = S_IDLE;
      end
      S_WB_RD: begin
        vc_slot    = slot_q;
        vc_read_en = 1'b1;
        state_d    = S_WB_LATCH;
      end
      S_WB_LATCH: begin
        wb_data_d = vc_data_rdata;
        wb_addr_d = {tag_q[slot_q], index_q[slot_q]};
        state_d   = S_WB_SEND;
      end
      S_WB_SEND: begin
        wb_valid = 1'b1;
        if (wb_ready) begin
          state_d = S_ALLOC;
        end
      end
      S_ALLOC: begin
        vc_slot            = slot_q;
        vc_we              = 1'b1;
        vc_tagvindex_wdata = {1'b1, evict_tag, evict_index};
        evict_done         = 1'b1;
        valid_d[slot_q]    = 1'b1;
        dirty_d[slot_q]    = evict_dirty;
        tag_d[slot_q]      = evict_tag;
        index_d[slot_q]    = evict_index;
        state_d            = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      valid_q   <= '0;
      dirty_q   <= '0;
      rr_ptr_q  <= '0;
      slot_q    <= '0;
      hit_q     <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      // NOTE: the tag/index array is tiny flop storage, so it is reset too; nothing reads it while invalid anyway.
      for (int i = 0; i < SIZE; i++) begin
        tag_q[i]   <= '0;
        index_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      dirty_q   <= dirty_d;
      rr_ptr_q  <= rr_ptr_d;
      slot_q    <= slot_d;
      hit_q     <= hit_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      tag_q     <= tag_d;
      index_q   <= index_d;
    end
  end

  assign wb_addr = wb_addr_q;
  assign wb_data = wb_data_q;

`ifdef VICTIM_CTRL_STAT_EN
  logic [31:0] stat_hit_q, stat_miss_q;

  // Saturating lookup counters.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stat_hit_q  <= '0;
      stat_miss_q <= '0;
    end else if (resp_valid) begin
      if (resp_hit && stat_hit_q != 32'hFFFF_FFFF) begin
        stat_hit_q <= stat_hit_q + 32'd1;
      end
      if (!resp_hit && stat_miss_q != 32'hFFFF_FFFF) begin
        stat_miss_q <= stat_miss_q + 32'd1;
      end
    end
  end

  assign stat_hit  = stat_hit_q;
  assign stat_miss = stat_miss_q;
`endif

endmodule

// File: tb/tb_victim_cache_ctrl.sv
// Directed self-checking bench for victim_cache_ctrl; models the victim RAM with 1-cycle read latency.
module tb_victim_cache_ctrl;

  localparam int LW = 512;

  logic           clk;
  logic           resetn;
  logic           miss_req;
  logic [19:0]    miss_tag;
  logic [5:0]     miss_index;
  logic           miss_ack;
  logic           resp_valid;
  logic           resp_hit;
  logic           resp_dirty;
  logic [LW-1:0]  resp_line;
  logic           evict_valid;
  logic [19:0]    evict_tag;
  logic [5:0]     evict_index;
  logic           evict_dirty;
  logic           evict_done;
  logic [1:0]     vc_slot;
  logic           vc_we;
  logic           vc_read_en;
  logic [26:0]    vc_tagvindex_wdata;
  logic [LW-1:0]  vc_data_rdata;
  logic           wb_valid;
  logic           wb_ready;
  logic [25:0]    wb_addr;
  logic [LW-1:0]  wb_data;
`ifdef VICTIM_CTRL_STAT_EN
  logic [31:0]    stat_hit;
  logic [31:0]    stat_miss;
`endif

  logic [LW-1:0]  evict_line;
  logic [LW-1:0]  ram [4];

  int n_cmp = 0;
  int n_err = 0;

  victim_cache_ctrl dut (
    .clk                (clk),
    .resetn             (resetn),
    .miss_req           (miss_req),
    .miss_tag           (miss_tag),
    .miss_index         (miss_index),
    .miss_ack           (miss_ack),
    .resp_valid         (resp_valid),
    .resp_hit           (resp_hit),
    .resp_dirty         (resp_dirty),
    .resp_line          (resp_line),
`ifdef VICTIM_CTRL_STAT_EN
    .stat_hit           (stat_hit),
    .stat_miss          (stat_miss),
`endif
    .evict_valid        (evict_valid),
    .evict_tag          (evict_tag),
    .evict_index        (evict_index),
    .evict_dirty        (evict_dirty),
    .evict_done         (evict_done),
    .vc_slot            (vc_slot),
    .vc_we              (vc_we),
    .vc_read_en         (vc_read_en),
    .vc_tagvindex_wdata (vc_tagvindex_wdata),
    .vc_data_rdata      (vc_data_rdata),
    .wb_valid           (wb_valid),
    .wb_ready           (wb_ready),
    .wb_addr            (wb_addr),
    .wb_data            (wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Victim RAM: L1 supplies the write data directly, reads return one cycle later.
  always @(posedge clk) begin
    if (vc_we) ram[vc_slot] <= evict_line;
    if (vc_read_en) vc_data_rdata <= ram[vc_slot];
  end

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, want);
    end
  endtask

  function automatic logic [LW-1:0] mk_line(input logic [31:0] seed);
    logic [LW-1:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = seed ^ (32'h0101_0101 * i);
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    miss_req = 1'b0;
    evict_valid = 1'b0;
    wb_ready = 1'b0;
    #1;
    check("rst_wb_valid", wb_valid, 1'b0);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic do_miss(input logic [19:0] tag, input logic [5:0] idx,
                         input logic exp_hit, input logic exp_dirty, input logic [LW-1:0] line);
    @(negedge clk);
    miss_req = 1'b1;
    miss_tag = tag;
    miss_index = idx;
    #1;
    check("miss_ack", miss_ack, 1'b1);
    @(negedge clk);
    miss_req = 1'b0;
    #1;
    check("miss_ack_pulse", miss_ack, 1'b0);
    if (!exp_hit) begin
      check("miss_resp_valid", resp_valid, 1'b1);
      check("miss_resp_hit", resp_hit, 1'b0);
    end else begin
      check("hit_resp_early", resp_valid, 1'b0);
      check("hit_read_en", vc_read_en, 1'b1);
      @(negedge clk);
      #1;
      check("hit_resp_valid", resp_valid, 1'b1);
      check("hit_resp_hit", resp_hit, 1'b1);
      check("hit_resp_dirty", resp_dirty, exp_dirty);
      check("hit_resp_line", resp_line, line);
    end
  endtask

  // stall < 0: no writeback expected; otherwise wb_ready is held low for 'stall' wb_valid cycles.
  task automatic do_evict(input logic [19:0] tag, input logic [5:0] idx, input logic dirty,
                          input logic [LW-1:0] line, input int exp_slot, input int stall,
                          input logic [25:0] wb_a, input logic [LW-1:0] wb_d);
    int  cyc;
    int  wbc;
    bit  done;
    @(negedge clk);
    evict_valid = 1'b1;
    evict_tag = tag;
    evict_index = idx;
    evict_dirty = dirty;
    evict_line = line;
    wb_ready = 1'b0;
    cyc = 0;
    wbc = 0;
    done = 1'b0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      #1;
      cyc++;
      if (wb_valid) begin
        wbc++;
        check("wb_addr", wb_addr, wb_a);
        check("wb_data", wb_data, wb_d);
        wb_ready = (wbc > stall);
      end
      if (evict_done) done = 1'b1;
    end
    wb_ready = 1'b0;
    check("evict_done_seen", done, 1'b1);
    check("evict_latency", cyc, (stall < 0) ? 1 : 4 + stall);
    check("wb_cycles", wbc, (stall < 0) ? 0 : stall + 1);
    check("alloc_slot", vc_slot, exp_slot);
    check("alloc_we", vc_we, 1'b1);
    check("alloc_wdata", vc_tagvindex_wdata, {1'b1, tag, idx});
    evict_valid = 1'b0;
  endtask

  initial begin
    resetn = 1'b0;
    miss_req = 1'b0;
    miss_tag = '0;
    miss_index = '0;
    evict_valid = 1'b0;
    evict_tag = '0;
    evict_index = '0;
    evict_dirty = 1'b0;
    evict_line = '0;
    wb_ready = 1'b0;
    #3;
    check("rst_ctrl", {miss_ack, resp_valid, resp_hit, evict_done, vc_we, vc_read_en, wb_valid}, 7'd0);
    check("rst_vc_slot", vc_slot, 2'd0);
    check("rst_wb_addr", wb_addr, 26'd0);
    check("rst_wb_data", wb_data, '0);
    @(negedge clk);
    resetn = 1'b1;

    // 1: empty cache misses with 1-cycle latency.
    do_miss(20'h12345, 6'h05, 1'b0, 1'b0, '0);

    // 2: dirty eviction into slot 0, hit returns it and frees the slot.
    do_evict(20'h12345, 6'h05, 1'b1, mk_line(32'hA5A5_0000), 0, -1, '0, '0);
    do_miss(20'h12345, 6'h05, 1'b1, 1'b1, mk_line(32'hA5A5_0000));
    do_miss(20'h12345, 6'h05, 1'b0, 1'b0, '0);

    // 3: clean fill, then round-robin overwrite without writeback.
    for (int i = 0; i < 4; i++)
      do_evict(20'hC0000 + 20'(i), 6'(i + 1), 1'b0, mk_line(32'hC000_0000 + i), i, -1, '0, '0);
    do_evict(20'hC0004, 6'h05, 1'b0, mk_line(32'hC000_0004), 0, -1, '0, '0);
    do_evict(20'hC0005, 6'h06, 1'b0, mk_line(32'hC000_0005), 1, -1, '0, '0);
    do_miss(20'hC0004, 6'h05, 1'b1, 1'b0, mk_line(32'hC000_0004));
    do_miss(20'hC0000, 6'h01, 1'b0, 1'b0, '0);
    do_miss(20'hC0002, 6'h07, 1'b0, 1'b0, '0);
    do_miss(20'hC0002, 6'h03, 1'b1, 1'b0, mk_line(32'hC000_0002));

    // 4: dirty fill, then a victim forces writeback of slot 0 with 3 stall cycles.
    do_reset();
    for (int i = 0; i < 4; i++)
      do_evict(20'hD0000 + 20'(i), 6'(i + 8), 1'b1, mk_line(32'hD000_0000 + i), i, -1, '0, '0);
    do_evict(20'hE0000, 6'h20, 1'b0, mk_line(32'hE000_0000), 0, 3,
             {20'hD0000, 6'h08}, mk_line(32'hD000_0000));

    // 5: simultaneous miss and evict: miss first, eviction in the following IDLE cycle.
    @(negedge clk);
    miss_req = 1'b1;
    miss_tag = 20'hD0001;
    miss_index = 6'h09;
    evict_valid = 1'b1;
    evict_tag = 20'hF0000;
    evict_index = 6'h21;
    evict_dirty = 1'b0;
    evict_line = mk_line(32'hF000_0000);
    #1;
    check("prio_miss_ack", miss_ack, 1'b1);
    check("prio_no_done", evict_done, 1'b0);
    @(negedge clk);
    miss_req = 1'b0;
    #1;
    check("prio_lookup_rd", vc_read_en, 1'b1);
    @(negedge clk);
    #1;
    check("prio_hit", {resp_valid, resp_hit, resp_dirty}, 3'b111);
    check("prio_line", resp_line, mk_line(32'hD000_0001));
    @(negedge clk);
    #1;
    check("prio_idle_no_done", evict_done, 1'b0);
    @(negedge clk);
    #1;
    check("prio_done", evict_done, 1'b1);
    check("prio_slot", vc_slot, 2'd1);
    evict_valid = 1'b0;

    // 6: reset during WB_SEND abandons the writeback.
    do_evict(20'hF1000, 6'h22, 1'b0, mk_line(32'hF100_0000), 1, -1, '0, '0);
    @(negedge clk);
    evict_valid = 1'b1;
    evict_tag = 20'hF2000;
    evict_index = 6'h23;
    evict_dirty = 1'b1;
    evict_line = mk_line(32'hF200_0000);
    wb_ready = 1'b0;
    @(negedge clk);
    #1;
    check("r6_wb_rd", {vc_read_en, vc_slot}, {1'b1, 2'd2});
    @(negedge clk);
    @(negedge clk);
    #1;
    check("r6_wb_valid", wb_valid, 1'b1);
    check("r6_wb_addr", wb_addr, {20'hD0002, 6'h0A});
    #2;
    resetn = 1'b0;
    #1;
    check("r6_wb_drop", wb_valid, 1'b0);
    check("r6_no_done", {evict_done, vc_we}, 2'b00);
    check("r6_wb_addr_clr", wb_addr, 26'd0);
    evict_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    do_miss(20'hE0000, 6'h20, 1'b0, 1'b0, '0);
    do_miss(20'hF1000, 6'h22, 1'b0, 1'b0, '0);
    do_miss(20'hD0003, 6'h0B, 1'b0, 1'b0, '0);
    do_evict(20'h77777, 6'h3F, 1'b0, mk_line(32'h7777_0000), 0, -1, '0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
